// File: rtl/conv_tile_buffer_pkg.sv
// ConvLoopParam: shared constants and types for the ConvTop tile buffer.
//
// Contents:
//   TBUF_DATA_W  - default word width of pixel, weight and output words
//   TBUF_ADDR_W  - default word-index width of each internal memory
//   TBUF_BUS_AW  - default width of ConvTop's BRAM address buses
//   TBUF_CNT_W   - default width of the output-feature-group counter
//   tbuf_state_t - tile buffer control states
package ConvLoopParam;

    localparam int TBUF_DATA_W = 128;
    localparam int TBUF_ADDR_W = 8;
    localparam int TBUF_BUS_AW = 32;
    localparam int TBUF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE,
        DRAIN
    } tbuf_state_t;

endpackage

// File: rtl/conv_tile_buffer_ram.sv
// conv_buf_ram: single-port synchronous RAM used for the pixel, weight
// and output memories of the tile buffer.
//
// Ports:
//   clk     - clock
//   i_we    - write enable
//   i_addr  - word address, shared by the read and write paths
//   i_wdata - write data
//   o_rdata - registered read data, one cycle after the address
//
// The array has no reset, so tile contents survive a reset.
module conv_buf_ram #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read-before-write behaviour: the read port always returns the
    // previous contents of the addressed word one cycle later.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/conv_tile_buffer.sv
// conv_tile_buffer: memory-side responder for ConvTop.
//
// Holds one tile of input pixels, weights and output pixels. The host
// loads the pixel/weight memories, the buffer then serves ConvTop reads
// and captures its output writes, and after tile_done hands the output
// memory back to the host for draining.
//
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   read_en, bram_rd_addr              - ConvTop read request
//   input_pixels, weights, valid       - ConvTop read response (1-cycle latency)
//   write_en, bram_wr_addr,
//   output_pixels                      - ConvTop output write
//   tile_pof_done, tile_done           - ConvTop progress pulses
//   ready                              - tile loaded, ConvTop may run
//   host_wr_en, host_wr_sel, host_addr,
//   host_wdata, host_load_done         - host load side
//   host_rd_en, host_rdata,
//   host_rvalid, host_drain_done       - host drain side
//   pof_count                          - tile_pof_done pulses in this tile
//   drain_req                          - output memory ready for host
//   err                                - sticky protocol/range error
module conv_tile_buffer
    import ConvLoopParam::*;
#(
    parameter int DATA_W = TBUF_DATA_W,
    parameter int ADDR_W = TBUF_ADDR_W,
    parameter int BUS_AW = TBUF_BUS_AW,
    parameter int CNT_W  = TBUF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_en,
    input  logic [BUS_AW-1:0] bram_rd_addr,
    output logic [DATA_W-1:0] input_pixels,
    output logic [DATA_W-1:0] weights,
    output logic              valid,
    input  logic              write_en,
    input  logic [BUS_AW-1:0] bram_wr_addr,
    input  logic [DATA_W-1:0] output_pixels,
    input  logic              tile_pof_done,
    input  logic              tile_done,
    output logic              ready,
    input  logic              host_wr_en,
    input  logic              host_wr_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_load_done,
    input  logic              host_rd_en,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              host_drain_done,
    output logic [CNT_W-1:0]  pof_count,
    output logic              drain_req,
    output logic              err
);

    tbuf_state_t r_state;
    tbuf_state_t w_next;

    logic              w_in_serve;
    logic              w_in_drain;
    logic              w_host_wr_ok;
    logic              w_rd_oor;
    logic              w_wr_oor;
    logic              w_pix_we;
    logic              w_wgt_we;
    logic              w_out_we;
    logic [ADDR_W-1:0] w_in_addr;
    logic [ADDR_W-1:0] w_out_addr;
    logic [DATA_W-1:0] w_pix_q;
    logic [DATA_W-1:0] w_wgt_q;
    logic [DATA_W-1:0] w_out_q;

    logic              r_valid;
    logic              r_rd_oor;
    logic              r_hrvalid;
    logic [DATA_W-1:0] r_pix_hold;
    logic [DATA_W-1:0] r_wgt_hold;
    logic [DATA_W-1:0] r_host_hold;
    logic [CNT_W-1:0]  r_pof_count;
    logic              r_err;

    assign w_in_serve   = (r_state == SERVE);
    assign w_in_drain   = (r_state == DRAIN);
    assign w_host_wr_ok = host_wr_en && ((r_state == IDLE) || (r_state == LOAD));
    assign w_rd_oor     = (bram_rd_addr[BUS_AW-1:ADDR_W] != '0);
    assign w_wr_oor     = (bram_wr_addr[BUS_AW-1:ADDR_W] != '0);

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. In IDLE a load-done pulse wins over a write so a
    // previously loaded tile can be reused without touching the memories.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (host_load_done) begin
                    w_next = SERVE;
                end else if (host_wr_en) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                if (host_load_done) begin
                    w_next = SERVE;
                end
            end
            SERVE: begin
                if (tile_done) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (host_drain_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Memory port multiplexing. ConvTop owns the pixel/weight address only
    // while serving; the host owns it otherwise. The output memory takes
    // ConvTop writes in SERVE and the host drain address elsewhere.
    always_comb begin
        w_in_addr  = host_addr;
        w_out_addr = host_addr;
        w_pix_we   = w_host_wr_ok && !host_wr_sel;
        w_wgt_we   = w_host_wr_ok && host_wr_sel;
        w_out_we   = 1'b0;
        if (w_in_serve) begin
            w_in_addr  = bram_rd_addr[ADDR_W-1:0];
            w_out_addr = bram_wr_addr[ADDR_W-1:0];
            w_out_we   = write_en && !w_wr_oor;
        end
    end

    conv_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pix_ram (
        .clk     (clk),
        .i_we    (w_pix_we),
        .i_addr  (w_in_addr),
        .i_wdata (host_wdata),
        .o_rdata (w_pix_q)
    );

    conv_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wgt_ram (
        .clk     (clk),
        .i_we    (w_wgt_we),
        .i_addr  (w_in_addr),
        .i_wdata (host_wdata),
        .o_rdata (w_wgt_q)
    );

    conv_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_ram (
        .clk     (clk),
        .i_we    (w_out_we),
        .i_addr  (w_out_addr),
        .i_wdata (output_pixels),
        .o_rdata (w_out_q)
    );

    // The RAM read register already provides the one-cycle latency, so the
    // response is the RAM output while valid; otherwise the last presented
    // word is replayed from a hold register so the outputs stay stable.
    assign input_pixels = r_valid ? (r_rd_oor ? '0 : w_pix_q) : r_pix_hold;
    assign weights      = r_valid ? (r_rd_oor ? '0 : w_wgt_q) : r_wgt_hold;
    assign valid        = r_valid;
    assign host_rdata   = r_hrvalid ? w_out_q : r_host_hold;
    assign host_rvalid  = r_hrvalid;
    assign ready        = w_in_serve;
    assign drain_req    = w_in_drain;
    assign pof_count    = r_pof_count;
    assign err          = r_err;

    // Response flags and hold registers. A reset drops any read that was
    // sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_hrvalid   <= 1'b0;
            r_pix_hold  <= '0;
            r_wgt_hold  <= '0;
            r_host_hold <= '0;
        end else begin
            r_valid   <= read_en && w_in_serve;
            r_rd_oor  <= w_rd_oor;
            r_hrvalid <= host_rd_en && w_in_drain;
            if (r_valid) begin
                r_pix_hold <= input_pixels;
                r_wgt_hold <= weights;
            end
            if (r_hrvalid) begin
                r_host_hold <= host_rdata;
            end
        end
    end

    // Output-feature-group counter: cleared when a tile starts being
    // served, counts pulses only while serving, and simply wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pof_count <= '0;
        end else if ((w_next == SERVE) && !w_in_serve) begin
            r_pof_count <= '0;
        end else if (w_in_serve && tile_pof_done) begin
            r_pof_count <= r_pof_count + CNT_W'(1);
        end
    end

    // Sticky error flag: any access in the wrong state or outside the
    // memory range sets it, and only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((host_wr_en && !w_host_wr_ok) ||
                     ((read_en || write_en) && !w_in_serve) ||
                     (read_en && w_rd_oor) ||
                     (write_en && w_wr_oor)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_tile_buffer.sv
// tb_conv_tile_buffer: directed self-checking bench for conv_tile_buffer.
// Inputs are changed 1 ns after each rising edge and outputs are sampled
// at the same point, so every sample reflects the state after that edge.
module tb_conv_tile_buffer;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 8;
    localparam int BUS_AW = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              read_en;
    logic [BUS_AW-1:0] bram_rd_addr;
    logic [DATA_W-1:0] input_pixels;
    logic [DATA_W-1:0] weights;
    logic              valid;
    logic              write_en;
    logic [BUS_AW-1:0] bram_wr_addr;
    logic [DATA_W-1:0] output_pixels;
    logic              tile_pof_done;
    logic              tile_done;
    logic              ready;
    logic              host_wr_en;
    logic              host_wr_sel;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_load_done;
    logic              host_rd_en;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              host_drain_done;
    logic [CNT_W-1:0]  pof_count;
    logic              drain_req;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] patA5;

    conv_tile_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BUS_AW (BUS_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_en         (read_en),
        .bram_rd_addr    (bram_rd_addr),
        .input_pixels    (input_pixels),
        .weights         (weights),
        .valid           (valid),
        .write_en        (write_en),
        .bram_wr_addr    (bram_wr_addr),
        .output_pixels   (output_pixels),
        .tile_pof_done   (tile_pof_done),
        .tile_done       (tile_done),
        .ready           (ready),
        .host_wr_en      (host_wr_en),
        .host_wr_sel     (host_wr_sel),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_load_done  (host_load_done),
        .host_rd_en      (host_rd_en),
        .host_rdata      (host_rdata),
        .host_rvalid     (host_rvalid),
        .host_drain_done (host_drain_done),
        .pof_count       (pof_count),
        .drain_req       (drain_req),
        .err             (err)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it.
    task automatic applyStimulus(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed sequence following the tile lifecycle.
    initial begin
        patA5           = {16{8'hA5}};
        rst_n           = 1'b0;
        read_en         = 1'b0;
        bram_rd_addr    = '0;
        write_en        = 1'b0;
        bram_wr_addr    = '0;
        output_pixels   = '0;
        tile_pof_done   = 1'b0;
        tile_done       = 1'b0;
        host_wr_en      = 1'b0;
        host_wr_sel     = 1'b0;
        host_addr       = '0;
        host_wdata      = '0;
        host_load_done  = 1'b0;
        host_rd_en      = 1'b0;
        host_drain_done = 1'b0;

        // Reset values.
        applyStimulus(2);
        checkOutput("rst_ready",     ready,        0);
        checkOutput("rst_valid",     valid,        0);
        checkOutput("rst_drain_req", drain_req,    0);
        checkOutput("rst_err",       err,          0);
        checkOutput("rst_pof",       pof_count,    0);
        checkOutput("rst_pixels",    input_pixels, 0);
        checkOutput("rst_hrvalid",   host_rvalid,  0);
        rst_n = 1'b1;
        applyStimulus(1);

        // Load pixel[i] = i and weight[i] = ~i.
        for (int i = 0; i < 16; i++) begin
            host_wr_en  = 1'b1;
            host_addr   = ADDR_W'(i);
            host_wr_sel = 1'b0;
            host_wdata  = DATA_W'(i);
            applyStimulus(1);
            host_wr_sel = 1'b1;
            host_wdata  = ~DATA_W'(i);
            applyStimulus(1);
        end
        host_wr_en = 1'b0;
        checkOutput("load_not_ready", ready, 0);
        host_load_done = 1'b1;
        applyStimulus(1);
        host_load_done = 1'b0;
        checkOutput("load_ready", ready, 1);
        checkOutput("load_err",   err,   0);

        // Single read of address 5, then data hold when valid drops.
        read_en      = 1'b1;
        bram_rd_addr = 32'd5;
        applyStimulus(1);
        read_en = 1'b0;
        checkOutput("rd5_valid",   valid,        1);
        checkOutput("rd5_pixels",  input_pixels, 128'd5);
        checkOutput("rd5_weights", weights,      ~128'd5);
        applyStimulus(1);
        checkOutput("rd5_valid_low",   valid,        0);
        checkOutput("rd5_pixels_hold", input_pixels, 128'd5);

        // 16 back-to-back reads.
        read_en      = 1'b1;
        bram_rd_addr = 32'd0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("b2b_valid_%0d", i),   valid,        1);
            checkOutput($sformatf("b2b_pixels_%0d", i),  input_pixels, DATA_W'(i));
            checkOutput($sformatf("b2b_weights_%0d", i), weights,      ~DATA_W'(i));
            if (i < 15) begin
                bram_rd_addr = 32'(i + 1);
            end else begin
                read_en = 1'b0;
            end
        end
        applyStimulus(1);
        checkOutput("b2b_end_valid", valid, 0);
        checkOutput("serve_err_clean", err, 0);

        // Out-of-range read: valid with zero data, err set.
        read_en      = 1'b1;
        bram_rd_addr = 32'h100;
        applyStimulus(1);
        read_en = 1'b0;
        checkOutput("oor_valid",   valid,        1);
        checkOutput("oor_pixels",  input_pixels, 0);
        checkOutput("oor_weights", weights,      0);
        checkOutput("oor_err",     err,          1);

        // Host write while serving is dropped.
        host_wr_en  = 1'b1;
        host_wr_sel = 1'b0;
        host_addr   = 8'd2;
        host_wdata  = 128'hDEAD;
        applyStimulus(1);
        host_wr_en   = 1'b0;
        read_en      = 1'b1;
        bram_rd_addr = 32'd2;
        applyStimulus(1);
        read_en = 1'b0;
        checkOutput("hostwr_serve_valid",  valid,        1);
        checkOutput("hostwr_serve_pixels", input_pixels, 128'd2);

        // Output write, three group pulses, drain_done ignored in SERVE.
        write_en      = 1'b1;
        bram_wr_addr  = 32'd3;
        output_pixels = patA5;
        applyStimulus(1);
        write_en      = 1'b0;
        tile_pof_done = 1'b1;
        applyStimulus(3);
        tile_pof_done = 1'b0;
        checkOutput("pof_three", pof_count, 3);
        host_drain_done = 1'b1;
        applyStimulus(1);
        host_drain_done = 1'b0;
        checkOutput("drain_done_in_serve", ready, 1);

        // tile_done with a concurrent read: read still returned.
        tile_done    = 1'b1;
        read_en      = 1'b1;
        bram_rd_addr = 32'd7;
        applyStimulus(1);
        tile_done = 1'b0;
        read_en   = 1'b0;
        checkOutput("td_ready",     ready,        0);
        checkOutput("td_drain_req", drain_req,    1);
        checkOutput("td_valid",     valid,        1);
        checkOutput("td_pixels",    input_pixels, 128'd7);
        checkOutput("td_pof_hold",  pof_count,    3);

        // Host drain read of address 3.
        host_rd_en = 1'b1;
        host_addr  = 8'd3;
        applyStimulus(1);
        host_rd_en = 1'b0;
        checkOutput("drain_rvalid", host_rvalid, 1);
        checkOutput("drain_rdata",  host_rdata,  patA5);
        applyStimulus(1);
        checkOutput("drain_rvalid_low", host_rvalid, 0);
        host_drain_done = 1'b1;
        applyStimulus(1);
        host_drain_done = 1'b0;
        checkOutput("idle_drain_req", drain_req, 0);
        checkOutput("idle_ready",     ready,     0);

        // Re-enter SERVE, count one pulse, then reset alongside a read.
        host_load_done = 1'b1;
        applyStimulus(1);
        host_load_done = 1'b0;
        checkOutput("reuse_ready",   ready,     1);
        checkOutput("reuse_pof_clr", pof_count, 0);
        tile_pof_done = 1'b1;
        applyStimulus(1);
        tile_pof_done = 1'b0;
        checkOutput("pre_rst_pof", pof_count, 1);
        rst_n        = 1'b0;
        read_en      = 1'b1;
        bram_rd_addr = 32'd1;
        applyStimulus(1);
        rst_n   = 1'b1;
        read_en = 1'b0;
        checkOutput("midrst_valid", valid,     0);
        checkOutput("midrst_ready", ready,     0);
        checkOutput("midrst_pof",   pof_count, 0);
        checkOutput("midrst_err",   err,       0);

        // Read in IDLE: dropped, err set.
        read_en      = 1'b1;
        bram_rd_addr = 32'd1;
        applyStimulus(1);
        read_en = 1'b0;
        checkOutput("idle_rd_valid", valid, 0);
        checkOutput("idle_rd_err",   err,   1);

        // Load-done alone reuses the tile; memory survived reset.
        host_load_done = 1'b1;
        applyStimulus(1);
        host_load_done = 1'b0;
        checkOutput("post_rst_ready", ready, 1);
        read_en      = 1'b1;
        bram_rd_addr = 32'd9;
        applyStimulus(1);
        read_en = 1'b0;
        checkOutput("post_rst_valid",  valid,        1);
        checkOutput("post_rst_pixels", input_pixels, 128'd9);

        // Drive pof_count to 0xFFFF, then wrap it together with tile_done.
        tile_pof_done = 1'b1;
        applyStimulus(65535);
        checkOutput("pof_max", pof_count, 16'hFFFF);
        tile_done = 1'b1;
        applyStimulus(1);
        tile_pof_done = 1'b0;
        tile_done     = 1'b0;
        checkOutput("wrap_pof",       pof_count, 0);
        checkOutput("wrap_drain_req", drain_req, 1);
        checkOutput("wrap_ready",     ready,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
